bcd_display_counter: RTL and testbench

Parametrised multi-digit BCD counter with seven-segment digit drivers. It generalises the fixed four-digit counter/display lab block to N digits, with a programmable tick prescaler, up/down counting, synchronous load, and wrap or saturate mode. It sits between the board clock/reset and the HEX display pins, and also exports the raw BCD count for other logic.

---
 rtl/bcd_display_counter.sv | 152 +++++++++++++++
 tb/tb_bcd_display_counter.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_display_counter.sv
// bcd_display_counter: N-digit BCD up/down counter with a tick prescaler,
// synchronous load, wrap-or-saturate at the terminal value, and registered
// seven-segment drivers (optional leading-zero blanking, optional inversion).
module bcd_display_counter #(
  parameter int DIGITS     = 4,     // 1..8 BCD digits
  parameter int DIV        = 1,     // clock cycles per count tick, >= 1
  parameter bit WRAP       = 1'b1,  // 1 = wrap at terminal value, 0 = saturate
  parameter bit BLANK_LZ   = 1'b0,  // 1 = blank leading zeros (digit 0 never blank)
  parameter bit ACTIVE_LOW = 1'b1   // 1 = lit segment driven as 0
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                en_i,
  input  logic                up_i,
  input  logic                load_i,
  input  logic [4*DIGITS-1:0] load_val_i,
  output logic [4*DIGITS-1:0] count_o,
  output logic                tc_o,
  output logic [7*DIGITS-1:0] ss_o
);

  localparam int CW    = 4 * DIGITS;
  localparam int SW    = 7 * DIGITS;
  localparam int PSC_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PSC_W-1:0] PSC_MAX = PSC_W'(DIV - 1);

  // Active-high segment pattern {g,f,e,d,c,b,a} for one BCD digit.
  function automatic logic [6:0] seg_code(input logic [3:0] d);
    case (d)
      4'd0:    seg_code = 7'h3F;
      4'd1:    seg_code = 7'h06;
      4'd2:    seg_code = 7'h5B;
      4'd3:    seg_code = 7'h4F;
      4'd4:    seg_code = 7'h66;
      4'd5:    seg_code = 7'h6D;
      4'd6:    seg_code = 7'h7D;
      4'd7:    seg_code = 7'h07;
      4'd8:    seg_code = 7'h7F;
      4'd9:    seg_code = 7'h6F;
      default: seg_code = 7'h00;
    endcase
  endfunction

  // Full display image for a BCD value, with blanking and polarity applied.
  function automatic logic [SW-1:0] encode(input logic [CW-1:0] cnt);
    logic       zero_above;
    logic [3:0] dig;
    logic [6:0] code;
    encode     = '0;
    zero_above = 1'b1;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      dig        = cnt[4*k +: 4];
      zero_above = zero_above & (dig == 4'd0);
      code       = seg_code(dig);
      if (BLANK_LZ && (k != 0) && zero_above) code = 7'h00;
      if (ACTIVE_LOW) code = ~code;
      encode[7*k +: 7] = code;
    end
  endfunction

  logic [PSC_W-1:0] psc_q, psc_d;
  logic [CW-1:0]    count_q, count_d;
  logic             tc_q, tc_d;
  logic [SW-1:0]    ss_q, ss_d;

  logic             tick;
  logic [CW-1:0]    inc_val, dec_val, load_clamped;
  logic             at_max, at_min;

  assign tick = en_i & (psc_q == PSC_MAX);

  // Prescaler: free-runs 0..DIV-1 while enabled; a load restarts the period.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    psc_d = psc_q;
    if (load_i || tick) psc_d = '0;
    else if (en_i)      psc_d = psc_q + PSC_W'(1);
  end

  // BCD increment/decrement with ripple carry/borrow, and load-value clamping.
  always_comb begin
    logic carry;
    logic borrow;
    carry        = 1'b1;
    borrow       = 1'b1;
    inc_val      = count_q;
    dec_val      = count_q;
    load_clamped = load_val_i;
    for (int k = 0; k < DIGITS; k++) begin
      if (carry) begin
        if (count_q[4*k +: 4] == 4'd9) begin
          inc_val[4*k +: 4] = 4'd0;
        end else begin
          inc_val[4*k +: 4] = count_q[4*k +: 4] + 4'd1;
          carry             = 1'b0;
        end
      end
      if (borrow) begin
        if (count_q[4*k +: 4] == 4'd0) begin
          dec_val[4*k +: 4] = 4'd9;
        end else begin
          dec_val[4*k +: 4] = count_q[4*k +: 4] - 4'd1;
          borrow            = 1'b0;
        end
      end
      if (load_val_i[4*k +: 4] > 4'd9) load_clamped[4*k +: 4] = 4'd9;
    end
    // A carry/borrow out of the top digit means the count sits at all-9s/all-0s.
    at_max = carry;
    at_min = borrow;
  end

  // Count/tc next state: load beats tick; terminal ticks pulse tc and wrap or hold.
  always_comb begin
    logic terminal;
    count_d  = count_q;
    tc_d     = 1'b0;
    terminal = up_i ? at_max : at_min;
    if (load_i) begin
      count_d = load_clamped;
    end else if (tick) begin
      tc_d = terminal;
      if (!terminal || WRAP) count_d = up_i ? inc_val : dec_val;
    end
  end

  // Display image follows the registered count, so ss lags count by one edge.
  always_comb begin
    ss_d = encode(count_q);
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    if (!rst_ni) begin
      psc_q   <= '0;
      count_q <= '0;
      tc_q    <= 1'b0;
      ss_q    <= encode({CW{1'b0}});
    end else begin
      psc_q   <= psc_d;
      count_q <= count_d;
      tc_q    <= tc_d;
      ss_q    <= ss_d;
    end
  end

  assign count_o = count_q;
  assign tc_o    = tc_q;
  assign ss_o    = ss_q;

endmodule

// File: tb/tb_bcd_display_counter.sv
// Scoreboard bench for bcd_display_counter: four instances with different
// parameter sets; stimulus queues expected outputs tagged with the edge at
// which they must appear, and a negedge monitor pops and compares them.
module tb_bcd_display_counter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Per-instance stimulus.
  logic        rst_n [4];
  logic        en    [4];
  logic        up    [4];
  logic        load  [4];
  logic [15:0] lv0, lv3;
  logic [7:0]  lv1, lv2;

  // Per-instance responses.
  logic [15:0] cnt0, cnt3;
  logic [7:0]  cnt1, cnt2;
  logic        tc0, tc1, tc2, tc3;
  logic [27:0] ss0, ss3;
  logic [13:0] ss1, ss2;

  // d0: 4 digits, prescaler 4, wrap, no blanking, active-low.
  bcd_display_counter #(.DIGITS(4), .DIV(4), .WRAP(1'b1), .BLANK_LZ(1'b0), .ACTIVE_LOW(1'b1)) u_d0 (
    .clk_i(clk), .rst_ni(rst_n[0]), .en_i(en[0]), .up_i(up[0]), .load_i(load[0]),
    .load_val_i(lv0), .count_o(cnt0), .tc_o(tc0), .ss_o(ss0));

  // d1: 2 digits, tick every cycle, wrap, active-low.
  bcd_display_counter #(.DIGITS(2), .DIV(1), .WRAP(1'b1), .BLANK_LZ(1'b0), .ACTIVE_LOW(1'b1)) u_d1 (
    .clk_i(clk), .rst_ni(rst_n[1]), .en_i(en[1]), .up_i(up[1]), .load_i(load[1]),
    .load_val_i(lv1), .count_o(cnt1), .tc_o(tc1), .ss_o(ss1));

  // d2: 2 digits, tick every cycle, saturate.
  bcd_display_counter #(.DIGITS(2), .DIV(1), .WRAP(1'b0), .BLANK_LZ(1'b0), .ACTIVE_LOW(1'b1)) u_d2 (
    .clk_i(clk), .rst_ni(rst_n[2]), .en_i(en[2]), .up_i(up[2]), .load_i(load[2]),
    .load_val_i(lv2), .count_o(cnt2), .tc_o(tc2), .ss_o(ss2));

  // d3: 4 digits, leading-zero blanking, active-high segments.
  bcd_display_counter #(.DIGITS(4), .DIV(1), .WRAP(1'b1), .BLANK_LZ(1'b1), .ACTIVE_LOW(1'b0)) u_d3 (
    .clk_i(clk), .rst_ni(rst_n[3]), .en_i(en[3]), .up_i(up[3]), .load_i(load[3]),
    .load_val_i(lv3), .count_o(cnt3), .tc_o(tc3), .ss_o(ss3));

  typedef struct {
    int          cyc;
    int          dut;
    logic [15:0] cnt;
    logic        tc;
    logic [27:0] ss;
    bit          chk_ss;
    string       name;
  } exp_t;

  exp_t sb_q[$];
  int   edge_cnt = 0;
  int   checks   = 0;
  int   failures = 0;

  // Count rising edges; expectations are keyed to this count.
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  // Queue an expectation for the state visible after k more rising edges.
  task automatic expect_at(input int k, input int dut, input logic [15:0] c,
                           input logic t, input logic [27:0] s, input bit cs,
                           input string nm);
    exp_t e;
    e.cyc    = edge_cnt + k;
    e.dut    = dut;
    e.cnt    = c;
    e.tc     = t;
    e.ss     = s;
    e.chk_ss = cs;
    e.name   = nm;
    sb_q.push_back(e);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor: on each falling edge, compare every expectation due now.
  always @(negedge clk) begin : monitor
    exp_t        e;
    logic [15:0] act_cnt;
    logic        act_tc;
    logic [27:0] act_ss;
    bit          ok;
    for (int i = sb_q.size() - 1; i >= 0; i--) begin
      if (sb_q[i].cyc <= edge_cnt) begin
        e = sb_q[i];
        sb_q.delete(i);
        case (e.dut)
          0:       begin act_cnt = cnt0;          act_tc = tc0; act_ss = ss0;          end
          1:       begin act_cnt = {8'h00, cnt1}; act_tc = tc1; act_ss = {14'h0, ss1}; end
          2:       begin act_cnt = {8'h00, cnt2}; act_tc = tc2; act_ss = {14'h0, ss2}; end
          default: begin act_cnt = cnt3;          act_tc = tc3; act_ss = ss3;          end
        endcase
        checks++;
        ok = (e.cyc == edge_cnt) && (act_cnt === e.cnt) && (act_tc === e.tc) &&
             (!e.chk_ss || (act_ss === e.ss));
        if (!ok) begin
          failures++;
          $display("FAIL %s (d%0d edge %0d): got count=%h tc=%b ss=%h, want count=%h tc=%b ss=%h%s",
                   e.name, e.dut, edge_cnt, act_cnt, act_tc, act_ss, e.cnt, e.tc, e.ss,
                   e.chk_ss ? "" : " (ss not checked)");
        end
      end
    end
  end

  initial begin
    for (int i = 0; i < 4; i++) begin
      rst_n[i] = 1'b0;
      en[i]    = 1'b0;
      up[i]    = 1'b1;
      load[i]  = 1'b0;
    end
    lv0 = '0; lv1 = '0; lv2 = '0; lv3 = '0;

    // Reset held for two edges, then released with en low.
    step(2);
    expect_at(0, 0, 16'h0000, 1'b0, 28'h8102040, 1'b1, "rst_d0");
    expect_at(0, 3, 16'h0000, 1'b0, 28'h000003F, 1'b1, "rst_d3_blank");
    for (int i = 0; i < 4; i++) rst_n[i] = 1'b1;
    expect_at(1, 0, 16'h0000, 1'b0, 28'h8102040, 1'b1, "rel_idle_1");
    expect_at(3, 0, 16'h0000, 1'b0, 28'h8102040, 1'b1, "rel_idle_3");
    step(3);

    // d1: up count through carry and wrap, then down through wrap.
    en[1] = 1'b1; up[1] = 1'b1;
    expect_at(1,   1, 16'h01, 1'b0, 28'h0,    1'b0, "up_first");
    expect_at(10,  1, 16'h10, 1'b0, 28'h2010, 1'b1, "up_carry");
    expect_at(99,  1, 16'h99, 1'b0, 28'h0,    1'b0, "up_99");
    expect_at(100, 1, 16'h00, 1'b1, 28'h0810, 1'b1, "up_wrap_tc");
    expect_at(101, 1, 16'h01, 1'b0, 28'h2040, 1'b1, "up_after_wrap");
    step(101);
    en[1] = 1'b0;
    expect_at(1, 1, 16'h01, 1'b0, 28'h0, 1'b0, "en_low_hold");
    step(1);
    up[1] = 1'b0; en[1] = 1'b1;
    expect_at(1, 1, 16'h00, 1'b0, 28'h0, 1'b0, "down_to_0");
    expect_at(2, 1, 16'h99, 1'b1, 28'h0, 1'b0, "down_wrap_tc");
    step(2);
    en[1] = 1'b0;
    expect_at(1, 1, 16'h99, 1'b0, 28'h0, 1'b0, "down_tc_clear");
    step(1);

    // d2: saturate down at 00 and up at 99.
    load[2] = 1'b1; lv2 = 8'h01;
    expect_at(1, 2, 16'h01, 1'b0, 28'h0, 1'b0, "sat_load");
    step(1);
    load[2] = 1'b0; up[2] = 1'b0; en[2] = 1'b1;
    expect_at(1, 2, 16'h00, 1'b0, 28'h0, 1'b0, "sat_down_00");
    expect_at(2, 2, 16'h00, 1'b1, 28'h0, 1'b0, "sat_hold_tc1");
    expect_at(3, 2, 16'h00, 1'b1, 28'h0, 1'b0, "sat_hold_tc2");
    step(3);
    load[2] = 1'b1; lv2 = 8'h99; up[2] = 1'b1;
    expect_at(1, 2, 16'h99, 1'b0, 28'h0, 1'b0, "sat_load_wins");
    step(1);
    load[2] = 1'b0;
    expect_at(1, 2, 16'h99, 1'b1, 28'h0, 1'b0, "sat_up_tc1");
    expect_at(2, 2, 16'h99, 1'b1, 28'h0, 1'b0, "sat_up_tc2");
    step(2);
    en[2] = 1'b0;
    expect_at(1, 2, 16'h99, 1'b0, 28'h0, 1'b0, "sat_en_low");
    step(1);

    // d0: prescaler 4, load with clamp mid-period, then reset mid-count.
    en[0] = 1'b1; up[0] = 1'b1;
    expect_at(3, 0, 16'h0000, 1'b0, 28'h0, 1'b0, "psc_before_tick");
    expect_at(4, 0, 16'h0001, 1'b0, 28'h0, 1'b0, "psc_tick_4");
    expect_at(8, 0, 16'h0002, 1'b0, 28'h0, 1'b0, "psc_tick_8");
    step(10);
    load[0] = 1'b1; lv0 = 16'h003C;
    expect_at(1, 0, 16'h0039, 1'b0, 28'h0, 1'b0, "psc_load_clamp");
    step(1);
    load[0] = 1'b0;
    expect_at(1, 0, 16'h0039, 1'b0, 28'h0,       1'b0, "psc_no_tick_12");
    expect_at(3, 0, 16'h0039, 1'b0, 28'h0,       1'b0, "psc_no_tick_14");
    expect_at(4, 0, 16'h0040, 1'b0, 28'h0,       1'b0, "psc_after_load");
    expect_at(5, 0, 16'h0040, 1'b0, 28'h8100CC0, 1'b1, "psc_ss_0040");
    step(12);
    expect_at(0, 0, 16'h0042, 1'b0, 28'h0, 1'b0, "pre_reset_0042");
    rst_n[0] = 1'b0;
    expect_at(1, 0, 16'h0000, 1'b0, 28'h8102040, 1'b1, "mid_reset");
    step(1);
    rst_n[0] = 1'b1;
    expect_at(1, 0, 16'h0000, 1'b0, 28'h8102040, 1'b1, "post_reset_ss");
    expect_at(3, 0, 16'h0000, 1'b0, 28'h0,       1'b0, "post_reset_wait");
    expect_at(4, 0, 16'h0001, 1'b0, 28'h0,       1'b0, "post_reset_tick");
    step(4);
    en[0] = 1'b0;

    // d3: leading-zero blanking, clamp, and 4-digit wrap.
    load[3] = 1'b1; lv3 = 16'h0050;
    expect_at(1, 3, 16'h0050, 1'b0, 28'h0,       1'b0, "lz_load");
    expect_at(2, 3, 16'h0050, 1'b0, 28'h00036BF, 1'b1, "lz_ss_0050");
    step(1);
    load[3] = 1'b0;
    step(1);
    load[3] = 1'b1; lv3 = 16'h0A0F;
    expect_at(1, 3, 16'h0909, 1'b0, 28'h0,       1'b0, "lz_clamp");
    expect_at(2, 3, 16'h0909, 1'b0, 28'h01BDFEF, 1'b1, "lz_ss_0909");
    step(2);
    lv3 = 16'h9999; up[3] = 1'b1; en[3] = 1'b1;
    expect_at(1, 3, 16'h9999, 1'b0, 28'h0, 1'b0, "lz_load_wins");
    step(1);
    load[3] = 1'b0;
    expect_at(1, 3, 16'h0000, 1'b1, 28'h0,       1'b0, "lz_wrap_tc");
    expect_at(2, 3, 16'h0001, 1'b0, 28'h000003F, 1'b1, "lz_ss_zero");
    step(2);
    en[3] = 1'b0;

    // Drain the scoreboard with a bounded wait.
    for (int i = 0; i < 50 && sb_q.size() != 0; i++) @(negedge clk);
    #1;
    if (sb_q.size() != 0) begin
      failures += sb_q.size();
      $display("FAIL scoreboard_drain: pending=%0d required=0", sb_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
